// File: rtl/acc_stack_reg_if.sv
// Command/data bundle for acc_stack_reg. The master side (control unit)
// drives commands and operands; the slave side (the accumulator) returns
// the visible value, flags and stack status.
// Optional feature macro: ACC_BYPASS_EN adds the 'pass' bypass select.
interface acc_stack_reg_if #(
    parameter int WIDTH     = 19,
    parameter int IMM_WIDTH = 8,
    parameter int LVL_W     = 3
);
    logic                 ld_alu;
    logic                 ld_mi;
    logic                 clear;
    logic                 inc;
    logic                 dec;
    logic                 push;
    logic                 pop;
    logic                 err_clr;
`ifdef ACC_BYPASS_EN
    logic                 pass;
`endif
    logic [WIDTH-1:0]     data_in_alu;
    logic [IMM_WIDTH-1:0] data_in_mi;
    logic [WIDTH-1:0]     data_out;
    logic                 z;
    logic                 z1;
    logic [LVL_W-1:0]     stk_level;
    logic                 stk_full;
    logic                 stk_empty;
    logic                 stk_err;

    modport master (
        output ld_alu, ld_mi, clear, inc, dec, push, pop, err_clr,
`ifdef ACC_BYPASS_EN
        output pass,
`endif
        output data_in_alu, data_in_mi,
        input  data_out, z, z1, stk_level, stk_full, stk_empty, stk_err
    );

    modport slave (
        input  ld_alu, ld_mi, clear, inc, dec, push, pop, err_clr,
`ifdef ACC_BYPASS_EN
        input  pass,
`endif
        input  data_in_alu, data_in_mi,
        output data_out, z, z1, stk_level, stk_full, stk_empty, stk_err
    );
endinterface

// File: rtl/acc_stack_reg.sv
// acc_stack_reg: WIDTH-bit accumulator with a DEPTH-entry LIFO save stack
// and zero / not-0-or-1 flags. All state changes on the falling clock edge.
// Optional feature macro: ACC_BYPASS_EN (combinational ALU bypass onto data_out).
module acc_stack_reg #(
    parameter int WIDTH     = 19,
    parameter int IMM_WIDTH = 8,
    parameter int DEPTH     = 4,
    parameter int LVL_W     = $clog2(DEPTH + 1)
) (
    input logic            clk,
    input logic            rst_n,
    acc_stack_reg_if.slave bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] ac;
    logic [WIDTH-1:0] ac_nxt;
    logic [LVL_W-1:0] level;
    logic             err;
    logic [WIDTH-1:0] stack [DEPTH];

    logic             empty;
    logic             full;
    logic             do_swap;
    logic             do_pop;
    logic             do_push;
    logic             both_empty;
    logic             new_err;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] top_idx;
    logic [WIDTH-1:0] vis;

    assign empty      = (level == '0);
    assign full       = (level == LVL_W'(DEPTH));
    assign wr_idx     = IDX_W'(level);
    assign top_idx    = IDX_W'(level - 1'b1);

    // Stack command decode: swap needs an entry; lone push/pop are gated by full/empty.
    assign do_swap    = bus.push &  bus.pop & ~empty;
    assign both_empty = bus.push &  bus.pop &  empty;
    assign do_pop     = bus.pop  & ~bus.push & ~empty;
    assign do_push    = bus.push & ~bus.pop  & ~full;
    assign new_err    = both_empty
                      | (bus.push & ~bus.pop & full)
                      | (bus.pop  & ~bus.push & empty);

    // Next AC: a successful pop/swap wins; a rejected push+pop freezes AC;
    // a rejected lone pop falls through to the remaining priority chain.
    always_comb begin
        ac_nxt = ac;
        if (do_swap || do_pop)
            ac_nxt = stack[top_idx];
        else if (both_empty)
            ac_nxt = ac;
        else if (bus.ld_alu)
            ac_nxt = bus.data_in_alu;
        else if (bus.ld_mi)
            ac_nxt = WIDTH'(bus.data_in_mi);
        else if (bus.clear)
            ac_nxt = '0;
        else if (bus.inc)
            ac_nxt = ac + 1'b1;
        else if (bus.dec)
            ac_nxt = ac - 1'b1;
    end

    // Accumulator, stack pointer and sticky error flag.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ac    <= '0;
            level <= '0;
            err   <= 1'b0;
        end else begin
            ac <= ac_nxt;
            if (do_push)
                level <= level + 1'b1;
            else if (do_pop)
                level <= level - 1'b1;
            if (new_err)
                err <= 1'b1;
            else if (bus.err_clr)
                err <= 1'b0;
        end
    end

    // Stack storage: no reset needed, writes always save the pre-edge AC.
    always_ff @(negedge clk) begin
        if (rst_n) begin
            if (do_swap)
                stack[top_idx] <= ac;
            else if (do_push)
                stack[wr_idx] <= ac;
        end
    end

    // Visible value: bypass only affects the output, never the stored AC.
`ifdef ACC_BYPASS_EN
    assign vis = bus.pass ? bus.data_in_alu : ac;
`else
    assign vis = ac;
`endif

    assign bus.data_out  = vis;
    assign bus.z         = (vis == '0);
    assign bus.z1        = (vis > WIDTH'(1));
    assign bus.stk_level = level;
    assign bus.stk_full  = full;
    assign bus.stk_empty = empty;
    assign bus.stk_err   = err;
endmodule

// File: tb/tb_acc_stack_reg.sv
// Directed bench for acc_stack_reg (WIDTH=19, IMM_WIDTH=8, DEPTH=4).
// Inputs change just after a falling edge; outputs are checked 1ns after it.
module tb_acc_stack_reg;
    localparam int WIDTH     = 19;
    localparam int IMM_WIDTH = 8;
    localparam int DEPTH     = 4;
    localparam int LVL_W     = $clog2(DEPTH + 1);

    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;

    acc_stack_reg_if #(.WIDTH(WIDTH), .IMM_WIDTH(IMM_WIDTH), .LVL_W(LVL_W)) bus ();

    acc_stack_reg #(.WIDTH(WIDTH), .IMM_WIDTH(IMM_WIDTH), .DEPTH(DEPTH), .LVL_W(LVL_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.ld_alu  = 1'b0;
        bus.ld_mi   = 1'b0;
        bus.clear   = 1'b0;
        bus.inc     = 1'b0;
        bus.dec     = 1'b0;
        bus.push    = 1'b0;
        bus.pop     = 1'b0;
        bus.err_clr = 1'b0;
`ifdef ACC_BYPASS_EN
        bus.pass    = 1'b0;
`endif
    endtask

    // Apply the currently driven command on the next falling edge.
    task automatic tick();
        @(negedge clk);
        #1;
        idle();
    endtask

    task automatic load(input logic [WIDTH-1:0] v, input logic with_push);
        bus.ld_alu      = 1'b1;
        bus.data_in_alu = v;
        bus.push        = with_push;
        tick();
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        idle();
        bus.data_in_alu = '0;
        bus.data_in_mi  = '0;
        rst_n = 1'b0;
        #3 rst_n = 1'b1;

        // Dirty the state, then reset between edges.
        load(19'h00123, 1'b0);
        load(19'h00456, 1'b1);
        check("pre_reset_ac", bus.data_out, 32'h456);
        check("pre_reset_lvl", bus.stk_level, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_data", bus.data_out, 32'h0);
        check("rst_z", bus.z, 32'd1);
        check("rst_z1", bus.z1, 32'd0);
        check("rst_empty", bus.stk_empty, 32'd1);
        check("rst_full", bus.stk_full, 32'd0);
        check("rst_lvl", bus.stk_level, 32'd0);
        check("rst_err", bus.stk_err, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Load priority: ld_alu beats ld_mi.
        bus.ld_alu = 1'b1; bus.data_in_alu = 19'h00005;
        bus.ld_mi  = 1'b1; bus.data_in_mi  = 8'hFF;
        tick();
        check("prio_ac", bus.data_out, 32'h5);
        check("prio_z", bus.z, 32'd0);
        check("prio_z1", bus.z1, 32'd1);
        bus.ld_mi = 1'b1; bus.data_in_mi = 8'h01;
        tick();
        check("mi_ac", bus.data_out, 32'h1);
        check("mi_z", bus.z, 32'd0);
        check("mi_z1", bus.z1, 32'd0);
        bus.ld_mi = 1'b1; bus.data_in_mi = 8'hFF;
        tick();
        check("mi_zext", bus.data_out, 32'h000FF);

        // Wrap both ways.
        bus.clear = 1'b1;
        tick();
        check("clear", bus.data_out, 32'h0);
        bus.dec = 1'b1;
        tick();
        check("dec_wrap", bus.data_out, 32'h7FFFF);
        check("dec_wrap_z1", bus.z1, 32'd1);
        bus.inc = 1'b1;
        tick();
        check("inc_wrap", bus.data_out, 32'h0);
        check("inc_wrap_z", bus.z, 32'd1);

        // Fill the stack with 1..4.
        load(19'd1, 1'b0);
        load(19'd2, 1'b1);
        load(19'd3, 1'b1);
        load(19'd4, 1'b1);
        bus.push = 1'b1;
        tick();
        check("fill_lvl", bus.stk_level, 32'd4);
        check("fill_full", bus.stk_full, 32'd1);
        check("fill_err", bus.stk_err, 32'd0);
        // Overflow: push dropped, concurrent load still applied.
        load(19'd6, 1'b1);
        check("ovf_err", bus.stk_err, 32'd1);
        check("ovf_lvl", bus.stk_level, 32'd4);
        check("ovf_ac", bus.data_out, 32'd6);
        for (int i = 4; i >= 1; i--) begin
            bus.pop = 1'b1;
            bus.ld_alu = 1'b1; bus.data_in_alu = 19'h1ABCD;
            tick();
            check("pop_val", bus.data_out, 32'(i));
            check("pop_lvl", bus.stk_level, 32'(i - 1));
        end
        check("pop_empty", bus.stk_empty, 32'd1);
        bus.err_clr = 1'b1;
        tick();
        check("err_clr", bus.stk_err, 32'd0);

        // Push with load, then swap.
        load(19'd7, 1'b0);
        load(19'd9, 1'b1);
        check("pushld_ac", bus.data_out, 32'd9);
        check("pushld_lvl", bus.stk_level, 32'd1);
        bus.push = 1'b1; bus.pop = 1'b1;
        tick();
        check("swap_ac", bus.data_out, 32'd7);
        check("swap_lvl", bus.stk_level, 32'd1);
        bus.pop = 1'b1;
        tick();
        check("swap_top", bus.data_out, 32'd9);
        check("swap_empty", bus.stk_empty, 32'd1);

        // Pop on empty falls through to inc.
        bus.pop = 1'b1; bus.inc = 1'b1;
        tick();
        check("upf_ac", bus.data_out, 32'd10);
        check("upf_err", bus.stk_err, 32'd1);
        bus.err_clr = 1'b1;
        tick();
        check("upf_clr", bus.stk_err, 32'd0);
        // New error beats err_clr.
        bus.pop = 1'b1; bus.err_clr = 1'b1;
        tick();
        check("err_wins", bus.stk_err, 32'd1);
        check("err_wins_ac", bus.data_out, 32'd10);
        bus.err_clr = 1'b1;
        tick();
        // Push+pop on empty freezes everything.
        bus.push = 1'b1; bus.pop = 1'b1;
        bus.ld_alu = 1'b1; bus.data_in_alu = 19'h00055;
        tick();
        check("pp_empty_ac", bus.data_out, 32'd10);
        check("pp_empty_lvl", bus.stk_level, 32'd0);
        check("pp_empty_err", bus.stk_err, 32'd1);

`ifdef ACC_BYPASS_EN
        load(19'd3, 1'b0);
        bus.pass = 1'b1; bus.data_in_alu = 19'd0;
        #1;
        check("byp_out", bus.data_out, 32'd0);
        check("byp_z", bus.z, 32'd1);
        bus.pass = 1'b0;
        #1;
        check("byp_off", bus.data_out, 32'd3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
